// File: rtl/fp_seq_pkg.sv
// fp_seq_pkg: shared types and constants for the AWP phase sequencer.
// The optional F8 watchdog is enabled by defining FP_SEQ_WATCHDOG_EN.
package fp_seq_pkg;

  // Sequencer states: idle, the nine phase lines, and the one-clock DONE.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_F2   = 4'd1,
    ST_F4   = 4'd2,
    ST_F5   = 4'd3,
    ST_F6   = 4'd4,
    ST_F7   = 4'd5,
    ST_F8   = 4'd6,
    ST_F9   = 4'd7,
    ST_F10  = 4'd8,
    ST_F13  = 4'd9,
    ST_DONE = 4'd10
  } state_e;

  // Position inside a 3-clock phase.
  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2
  } sub_e;

  // Operation classes as latched at start (ir values 0..7, NRF overrides ir).
  localparam logic [3:0] AD  = 4'd0;
  localparam logic [3:0] SD  = 4'd1;
  localparam logic [3:0] MW  = 4'd2;
  localparam logic [3:0] DW  = 4'd3;
  localparam logic [3:0] AF  = 4'd4;
  localparam logic [3:0] SF  = 4'd5;
  localparam logic [3:0] MF  = 4'd6;
  localparam logic [3:0] DF  = 4'd7;
  localparam logic [3:0] NRF = 4'd8;

  // Width of the F8 iteration counter used by the watchdog.
  localparam int LOOP_CNT_W = 6;

  // True for the states that drive a phase line and run the sub-cycle counter.
  function automatic logic is_phase(input state_e s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/fp_tick.sv
// fp_tick: 3-clock sub-cycle counter (T0 -> T1 -> T2 -> T0).
// restart holds the counter at T0 so every phase starts aligned.
module fp_tick
  import fp_seq_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic restart,
  output logic t1,
  output logic t2,
  output logic last
);

  sub_e sub_q;
  sub_e sub_d;

  // Next sub-cycle: wrap after T2, park at T0 while restart is high.
  always_comb begin
    sub_d = sub_q;
    if (restart) begin
      sub_d = T0;
    end else begin
      case (sub_q)
        T0:      sub_d = T1;
        T1:      sub_d = T2;
        T2:      sub_d = T0;
        default: sub_d = T0;
      endcase
    end
  end

  // Sub-cycle register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      sub_q <= T0;
    end else begin
      sub_q <= sub_d;
    end
  end

  assign t1   = (sub_q == T1);
  assign t2   = (sub_q == T2);
  assign last = (sub_q == T2);

endmodule

// File: rtl/fp_seq.sv
// fp_seq: AWP floating-point phase sequencer. Each phase is three clocks;
// the successor is chosen at the end of T2 from the latched class and the
// datapath conditions. Defining FP_SEQ_WATCHDOG_EN adds a bounded F8 loop.
module fp_seq
  import fp_seq_pkg::*;
#(
  parameter int LOOP_MAX = 63
) (
  input  logic       __clk,
  input  logic       clr,
  input  logic       start,
  input  logic [7:9] ir,
  input  logic       nrf,
  input  logic       g,
  input  logic       fic_z,
  input  logic       ws,
  input  logic       di,
  output logic       f2,
  output logic       f4,
  output logic       f5,
  output logic       f6,
  output logic       f7,
  output logic       f8,
  output logic       f9,
  output logic       f10,
  output logic       f13,
  output logic       strob_fp,
  output logic       strob2_fp,
  output logic       fclr,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_e     state_q, state_d;
  state_e     succ_s;
  logic [3:0] op_q, op_d;
  logic       fclr_q, fclr_d;
  logic       err_q, err_d;
  logic       corr_q, corr_d;
  logic       wd_trip_s;
  logic       restart_s;
  logic       tick_t1_s;
  logic       tick_t2_s;
  logic       tick_last_s;

  assign restart_s = !is_phase(state_q);

  fp_tick u_tick (
    .clk     (__clk),
    .clr     (clr),
    .restart (restart_s),
    .t1      (tick_t1_s),
    .t2      (tick_t2_s),
    .last    (tick_last_s)
  );

`ifdef FP_SEQ_WATCHDOG_EN
  localparam logic [LOOP_CNT_W-1:0] LOOP_LIM = LOOP_CNT_W'(LOOP_MAX - 1);

  logic [LOOP_CNT_W-1:0] loop_cnt_q, loop_cnt_d;

  // Count completed F8 iterations that ended without fic_z; zero outside F8.
  always_comb begin
    loop_cnt_d = {LOOP_CNT_W{1'b0}};
    if (state_q == ST_F8) begin
      if (tick_last_s && !fic_z) begin
        loop_cnt_d = loop_cnt_q + {{(LOOP_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        loop_cnt_d = loop_cnt_q;
      end
    end else begin
      loop_cnt_d = {LOOP_CNT_W{1'b0}};
    end
  end

  // F8 iteration counter register.
  always_ff @(posedge __clk) begin
    if (clr) begin
      loop_cnt_q <= {LOOP_CNT_W{1'b0}};
    end else begin
      loop_cnt_q <= loop_cnt_d;
    end
  end
`else
  // Without the watchdog the iteration limit has no consumer.
  logic unused_loop_max_s;
  assign unused_loop_max_s = (LOOP_MAX == 0);
`endif

  // Successor of the current phase for the latched class (used at T2 only).
  always_comb begin
    succ_s    = ST_DONE;
    wd_trip_s = 1'b0;
    case (state_q)
      ST_F2: begin
        case (op_q)
          AD, SD:  succ_s = ST_F6;
          NRF:     succ_s = ST_F8;
          default: succ_s = ST_F4;
        endcase
      end
      ST_F4: begin
        case (op_q)
          MW, MF:  succ_s = ST_F6;
          DW, DF:  succ_s = ST_F8;
          AF, SF:  succ_s = ST_F5;
          default: succ_s = ST_DONE;
        endcase
      end
      ST_F5: begin
        if (g) begin
          succ_s = ST_F13;
        end else begin
          succ_s = ST_F8;
        end
      end
      ST_F6: succ_s = ST_F7;
      ST_F7: begin
        case (op_q)
          AD, SD:  succ_s = ST_DONE;
          MW, MF:  succ_s = ST_F8;
          DW, DF:  succ_s = ST_F10;
          AF, SF:  succ_s = ST_F13;
          default: succ_s = ST_DONE;
        endcase
      end
      ST_F8: begin
        if (!fic_z) begin
          succ_s = ST_F8;
`ifdef FP_SEQ_WATCHDOG_EN
          if (loop_cnt_q == LOOP_LIM) begin
            succ_s    = ST_DONE;
            wd_trip_s = 1'b1;
          end else begin
            wd_trip_s = 1'b0;
          end
`endif
        end else begin
          case (op_q)
            MW:       succ_s = ST_DONE;
            MF, NRF:  succ_s = ST_F13;
            DW, DF:   succ_s = ST_F9;
            AF, SF:   succ_s = ST_F6;
            default:  succ_s = ST_DONE;
          endcase
        end
      end
      ST_F9: succ_s = ST_F10;
      ST_F10: begin
        // Only one correction pass: the flag blocks a second F7.
        if (ws && !corr_q) begin
          succ_s = ST_F7;
        end else if (op_q == DF) begin
          succ_s = ST_F13;
        end else begin
          succ_s = ST_DONE;
        end
      end
      ST_F13:  succ_s = ST_DONE;
      default: succ_s = ST_DONE;
    endcase
  end

  // Next-state logic: launch from IDLE, advance phases at T2, DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fclr_d  = 1'b0;
    err_d   = err_q;
    corr_d  = corr_q;
    case (state_q)
      ST_IDLE: begin
        if (fclr_q) begin
          state_d = ST_F2;
        end else if (start) begin
          op_d   = nrf ? NRF : {1'b0, ir};
          fclr_d = 1'b1;
          err_d  = 1'b0;
          corr_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        if (tick_last_s) begin
          if (di) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = succ_s;
            err_d   = err_q | wd_trip_s;
            corr_d  = corr_q | ((state_q == ST_F10) && (succ_s == ST_F7));
          end
        end else begin
          state_d = state_q;
        end
      end
    endcase
  end

  // Control registers; clr wins over everything including start.
  always_ff @(posedge __clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      op_q    <= AD;
      fclr_q  <= 1'b0;
      err_q   <= 1'b0;
      corr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fclr_q  <= fclr_d;
      err_q   <= err_d;
      corr_q  <= corr_d;
    end
  end

  // Outputs decode registered state only, so they are glitch-free.
  assign f2        = (state_q == ST_F2);
  assign f4        = (state_q == ST_F4);
  assign f5        = (state_q == ST_F5);
  assign f6        = (state_q == ST_F6);
  assign f7        = (state_q == ST_F7);
  assign f8        = (state_q == ST_F8);
  assign f9        = (state_q == ST_F9);
  assign f10       = (state_q == ST_F10);
  assign f13       = (state_q == ST_F13);
  assign strob_fp  = is_phase(state_q) && tick_t1_s;
  assign strob2_fp = is_phase(state_q) && tick_t2_s;
  assign fclr      = fclr_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_fp_seq.sv
// tb_fp_seq: directed self-checking bench for fp_seq.
module tb_fp_seq;

  logic       clk = 1'b0;
  logic       clr, start, nrf, g, fic_z, ws, di;
  logic [2:0] ir;
  logic       f2, f4, f5, f6, f7, f8, f9, f10, f13;
  logic       strob_fp, strob2_fp, fclr, busy, done, err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_seq #(.LOOP_MAX(63)) dut (
    .__clk(clk), .clr(clr), .start(start), .ir(ir), .nrf(nrf),
    .g(g), .fic_z(fic_z), .ws(ws), .di(di),
    .f2(f2), .f4(f4), .f5(f5), .f6(f6), .f7(f7), .f8(f8), .f9(f9),
    .f10(f10), .f13(f13), .strob_fp(strob_fp), .strob2_fp(strob2_fp),
    .fclr(fclr), .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] all_outs();
    return {f2, f4, f5, f6, f7, f8, f9, f10, f13,
            strob_fp, strob2_fp, fclr, busy, done, err};
  endfunction

  // Hex code of the active phase line; F when none or several are high.
  function automatic logic [3:0] phase_code();
    int n;
    n = int'(f2) + int'(f4) + int'(f5) + int'(f6) + int'(f7) +
        int'(f8) + int'(f9) + int'(f10) + int'(f13);
    if (n != 1) return 4'hF;
    if (f2)  return 4'h2;
    if (f4)  return 4'h4;
    if (f5)  return 4'h5;
    if (f6)  return 4'h6;
    if (f7)  return 4'h7;
    if (f8)  return 4'h8;
    if (f9)  return 4'h9;
    if (f10) return 4'hA;
    return 4'hD;
  endfunction

  // Launch one operation, drive conditions per phase, record the phase list.
  task automatic run_op(input string tag, input logic [2:0] cls, input logic nrf_v,
                        input logic g_v, input logic ws_v, input int fz_after,
                        input logic [3:0] di_code, input logic [63:0] exp_seq,
                        input int exp_len, input logic exp_err);
    logic [63:0] seq;
    logic [3:0]  code;
    int          ncyc, t2cnt, pos;
    logic        seen_done, ok_strb, ok_line;
    @(negedge clk);
    start = 1'b1; ir = cls; nrf = nrf_v; g = g_v; ws = ws_v; fic_z = 1'b0; di = 1'b0;
    @(negedge clk);
    check({tag, "_launch"}, {fclr, busy, err}, 3'b100);
    start = 1'b0;
    seq = 64'd0; ncyc = 0; t2cnt = 0;
    seen_done = 1'b0; ok_strb = 1'b1; ok_line = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      ncyc++;
      if (done) begin
        seen_done = 1'b1;
        start = 1'b0; di = 1'b0; ir = cls; nrf = nrf_v;
        check({tag, "_done"}, {busy, err}, {1'b1, exp_err});
        break;
      end
      code = phase_code();
      pos  = (ncyc - 1) % 3;
      if (code == 4'hF || busy !== 1'b1 || fclr !== 1'b0) ok_line = 1'b0;
      if (strob_fp !== (pos == 1) || strob2_fp !== (pos == 2)) ok_strb = 1'b0;
      if (pos == 0) seq = (seq << 4) | {60'd0, code};
      di = 1'b0;
      if (pos == 2) begin
        if (code == 4'h8) begin
          fic_z = (t2cnt >= fz_after);
          t2cnt++;
        end
        di = (code == di_code);
      end
      // Stray start and class changes mid-operation must be ignored.
      start = 1'b1; ir = ~cls; nrf = ~nrf_v;
    end
    check({tag, "_finished"}, seen_done, 1'b1);
    if (seen_done) begin
      check({tag, "_seq"}, seq, exp_seq);
      check({tag, "_cycles"}, ncyc, 3 * exp_len + 1);
      check({tag, "_lines"}, ok_line, 1'b1);
      check({tag, "_strobes"}, ok_strb, 1'b1);
      @(negedge clk);
      check({tag, "_idle"}, {busy, done, fclr, err}, {3'b000, exp_err});
    end else begin
      start = 1'b0; di = 1'b0;
    end
  endtask

  initial begin
    logic found;
    clr = 1'b1; start = 1'b0; ir = 3'd0; nrf = 1'b0;
    g = 1'b0; fic_z = 1'b0; ws = 1'b0; di = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", all_outs(), 15'd0);
    clr = 1'b0;

    //       tag      cls   nrf   g     ws    fz  di     expected phases             len err
    run_op("ad",     3'd0, 1'b0, 1'b0, 1'b0, 0, 4'h0, 64'h267,                3, 1'b0);
    run_op("sd_di",  3'd1, 1'b0, 1'b0, 1'b0, 0, 4'h6, 64'h26,                 2, 1'b1);
    @(negedge clk);
    check("err_held", err, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    check("clr_err", {busy, err}, 2'b00);
    clr = 1'b0;
    run_op("ad_di",  3'd0, 1'b0, 1'b0, 1'b0, 0, 4'h2, 64'h2,                  1, 1'b1);
    run_op("mw",     3'd2, 1'b0, 1'b0, 1'b0, 0, 4'h0, 64'h24678,              5, 1'b0);
    run_op("mf",     3'd6, 1'b0, 1'b0, 1'b0, 4, 4'h0, 64'h246788888D,        10, 1'b0);
    run_op("dw_ws0", 3'd3, 1'b0, 1'b0, 1'b0, 0, 4'h0, 64'h2489A,              5, 1'b0);
    run_op("dw_ws1", 3'd3, 1'b0, 1'b0, 1'b1, 0, 4'h0, 64'h2489A7A,            7, 1'b0);
    run_op("df_ws1", 3'd7, 1'b0, 1'b0, 1'b1, 2, 4'h0, 64'h248889A7AD,        10, 1'b0);
    run_op("af_g1",  3'd4, 1'b0, 1'b1, 1'b0, 0, 4'h0, 64'h245D,               4, 1'b0);
    run_op("sf_g0",  3'd5, 1'b0, 1'b0, 1'b0, 0, 4'h0, 64'h245867D,            7, 1'b0);
    run_op("nrf",    3'd0, 1'b1, 1'b0, 1'b0, 1, 4'h0, 64'h288D,               4, 1'b0);

    // clr in the middle of an F8 loop (fic_z stuck at 0).
    @(negedge clk);
    start = 1'b1; ir = 3'd6; nrf = 1'b0; fic_z = 1'b0; di = 1'b0; g = 1'b0; ws = 1'b0;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (f8 && strob_fp) begin
        found = 1'b1;
        break;
      end
    end
    check("clr_reach_f8t1", found, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    check("clr_mid_f8", all_outs(), 15'd0);
    clr = 1'b0;
    @(negedge clk);
    check("clr_stays_idle", all_outs(), 15'd0);

    // start and clr together: clr wins.
    start = 1'b1; clr = 1'b1; ir = 3'd0;
    @(negedge clk);
    check("start_clr_same", {fclr, busy}, 2'b00);
    start = 1'b0; clr = 1'b0;
    @(negedge clk);
    check("start_clr_after", {fclr, busy}, 2'b00);

    run_op("ad_again", 3'd0, 1'b0, 1'b0, 1'b0, 0, 4'h0, 64'h267, 3, 1'b0);

`ifdef FP_SEQ_WATCHDOG_EN
    run_op("wd", 3'd6, 1'b0, 1'b0, 1'b0, 1000, 4'h0, 64'h8888888888888888, 67, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
